// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared types and constants for the two-master on-chip RAM arbiter.
package onchip_mem_arbiter_pkg;

    localparam int unsigned NumMasters = 2;
    localparam int unsigned LockCntW   = 8;

    localparam logic Master0 = 1'b0;
    localparam logic Master1 = 1'b1;

    typedef enum logic [0:0] {
        StArb,
        StLock
    } arb_state_e;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle joining two Avalon-MM masters, the arbiter and a single-port RAM.
interface onchip_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    import onchip_mem_arbiter_pkg::*;

    localparam int unsigned BeW = DATA_W / 8;

    // Master side, packed master-major.
    logic [NumMasters*ADDR_W-1:0] m_address;
    logic [NumMasters*BeW-1:0]    m_byteenable;
    logic [NumMasters-1:0]        m_read;
    logic [NumMasters-1:0]        m_write;
    logic [NumMasters*DATA_W-1:0] m_writedata;
    logic [NumMasters-1:0]        m_lock;
    logic [NumMasters-1:0]        m_waitrequest;
    logic [NumMasters*DATA_W-1:0] m_readdata;
    logic [NumMasters-1:0]        m_readdatavalid;

    // RAM side.
    logic [ADDR_W-1:0] mem_address;
    logic [BeW-1:0]    mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    // Arbiter view.
    modport slave (
        input  m_address, m_byteenable, m_read, m_write, m_writedata, m_lock,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
        output mem_clken,
        input  mem_readdata
    );

    // Environment view: the masters plus the RAM.
    modport master (
        output m_address, m_byteenable, m_read, m_write, m_writedata, m_lock,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
        input  mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter for a single-port on-chip RAM with locked bursts.
// Grant is combinational so a granted access completes in the cycle it is presented.
module onchip_mem_arbiter
    import onchip_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    onchip_mem_arbiter_if.slave bus
);

    localparam int unsigned         BeW        = DATA_W / 8;
    localparam logic [LockCntW-1:0] MaxLockCnt = LockCntW'(MAX_LOCK);
    localparam bit                  LockEnable = (MAX_LOCK > 1);

    arb_state_e          state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic [LockCntW-1:0] lock_cnt_q, lock_cnt_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_master_q, rd_master_d;

    logic [NumMasters-1:0] req;
    logic                  gnt_valid;
    logic                  gnt_idx;
    logic                  gnt_wr;
    logic                  gnt_rd;
    logic [LockCntW-1:0]   lock_cnt_inc;

    assign req          = bus.m_read | bus.m_write;
    assign lock_cnt_inc = lock_cnt_q + LockCntW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StArb;
            last_grant_q <= Master1;
            owner_q      <= Master0;
            lock_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_master_q  <= Master0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_master_q  <= rd_master_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        rd_pend_d    = gnt_rd;
        rd_master_d  = gnt_idx;
        if (gnt_valid) begin
            last_grant_d = gnt_idx;
        end
        unique case (state_q)
            StArb: begin
                if (LockEnable && gnt_valid && bus.m_lock[gnt_idx]) begin
                    state_d    = StLock;
                    owner_d    = gnt_idx;
                    lock_cnt_d = LockCntW'(1);
                end
            end
            StLock: begin
                // In lock only the owner is ever granted, so no grant means the owner idled.
                if (!gnt_valid || !bus.m_lock[owner_q] || lock_cnt_inc >= MaxLockCnt) begin
                    state_d    = StArb;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_inc;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = Master0;
        if (reset_n) begin
            if (state_q == StLock) begin
                gnt_valid = req[owner_q];
                gnt_idx   = owner_q;
            end else if (&req) begin
                gnt_valid = 1'b1;
                gnt_idx   = ~last_grant_q;
            end else if (|req) begin
                gnt_valid = 1'b1;
                gnt_idx   = req[Master1] ? Master1 : Master0;
            end
        end
        // Read together with write is served as a write only.
        gnt_wr = gnt_valid & bus.m_write[gnt_idx];
        gnt_rd = gnt_valid & bus.m_read[gnt_idx] & ~bus.m_write[gnt_idx];

        bus.m_waitrequest = '1;
        if (gnt_valid) begin
            bus.m_waitrequest[gnt_idx] = 1'b0;
        end

        bus.mem_chipselect = gnt_valid;
        bus.mem_write      = gnt_wr;
        bus.mem_clken      = reset_n;
        bus.mem_address    = '0;
        bus.mem_byteenable = '0;
        bus.mem_writedata  = '0;
        if (gnt_valid) begin
            bus.mem_address    = gnt_idx ? bus.m_address[ADDR_W +: ADDR_W]
                                         : bus.m_address[0 +: ADDR_W];
            bus.mem_byteenable = gnt_idx ? bus.m_byteenable[BeW +: BeW]
                                         : bus.m_byteenable[0 +: BeW];
            bus.mem_writedata  = gnt_idx ? bus.m_writedata[DATA_W +: DATA_W]
                                         : bus.m_writedata[0 +: DATA_W];
        end

        bus.m_readdatavalid = '0;
        bus.m_readdata      = '0;
        if (rd_pend_q) begin
            bus.m_readdatavalid[rd_master_q] = 1'b1;
            if (rd_master_q) begin
                bus.m_readdata[DATA_W +: DATA_W] = bus.mem_readdata;
            end else begin
                bus.m_readdata[0 +: DATA_W] = bus.mem_readdata;
            end
        end
    end

endmodule
